// File: rtl/cmd_cfg.sv
// Host command interpreter: applies setpoint/motor commands from the UART receiver,
// sequences motor spin-up and inertial calibration, and returns a 0xA5 ACK per command.
module cmd_cfg #(
    parameter int FAST_SIM = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    input  logic        cal_done,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic [7:0]  resp,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    output logic        motors_off
);

    // state | meaning
    // IDLE  | accepting commands from the receiver
    // RAMP  | motors spinning up, spin-up timer running
    // CAL   | calibration started, waiting for cal_done
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        CAL  = 2'd2
    } state_t;

    localparam int              TW        = (FAST_SIM != 0) ? 9 : 26;
    localparam logic [TW-1:0]   TMR_ONE   = TW'(1);
    localparam logic [7:0]      OP_PTCH   = 8'h02;
    localparam logic [7:0]      OP_ROLL   = 8'h03;
    localparam logic [7:0]      OP_YAW    = 8'h04;
    localparam logic [7:0]      OP_THRST  = 8'h05;
    localparam logic [7:0]      OP_CAL    = 8'h06;
    localparam logic [7:0]      OP_EMER   = 8'h07;
    localparam logic [7:0]      OP_MOFF   = 8'h08;

    state_t          state;
    state_t          nxt_state;
    logic [TW-1:0]   timer;
    logic            accept;
    logic            go_cal;
    logic            ramp_done;

    assign resp         = 8'hA5;
    assign inertial_cal = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // strt_cal is high in the first CAL cycle; cal_done is not honoured in that cycle.
    always_comb begin
        nxt_state   = state;
        clr_cmd_rdy = 1'b0;
        send_resp   = 1'b0;
        accept      = 1'b0;
        go_cal      = 1'b0;
        ramp_done   = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy = 1'b1;
                    if (cmd == OP_CAL) begin
                        go_cal    = 1'b1;
                        nxt_state = RAMP;
                    end else begin
                        accept    = 1'b1;
                        send_resp = 1'b1;
                    end
                end
            end
            RAMP: begin
                if (&timer) begin
                    ramp_done = 1'b1;
                    nxt_state = CAL;
                end
            end
            CAL: begin
                if (cal_done && !strt_cal) begin
                    send_resp = 1'b1;
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer    <= '0;
            strt_cal <= 1'b0;
        end else begin
            strt_cal <= ramp_done;
            if (go_cal) begin
                timer <= '0;
            end else if (state == RAMP) begin
                timer <= timer + TMR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_ptch     <= '0;
            d_roll     <= '0;
            d_yaw      <= '0;
            thrst      <= '0;
            motors_off <= 1'b1;
        end else begin
            if (go_cal) begin
                motors_off <= 1'b0;
            end
            if (accept) begin
                case (cmd)
                    OP_PTCH:  d_ptch <= data;
                    OP_ROLL:  d_roll <= data;
                    OP_YAW:   d_yaw  <= data;
                    OP_THRST: thrst  <= data[8:0];
                    OP_EMER: begin
                        d_ptch <= '0;
                        d_roll <= '0;
                        d_yaw  <= '0;
                        thrst  <= '0;
                    end
                    OP_MOFF:  motors_off <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg: vector table, calibration/reset sequences,
// and randomized command streams against a setpoint model.
module tb_cmd_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cal_done;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [7:0]  resp;
    logic [15:0] d_ptch;
    logic [15:0] d_roll;
    logic [15:0] d_yaw;
    logic [8:0]  thrst;
    logic        strt_cal;
    logic        inertial_cal;
    logic        motors_off;

    always #5 clk = ~clk;

    cmd_cfg #(.FAST_SIM(1)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
        .cal_done(cal_done), .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp),
        .resp(resp), .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
        .thrst(thrst), .strt_cal(strt_cal), .inertial_cal(inertial_cal),
        .motors_off(motors_off)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_ptch, m_roll, m_yaw;
    logic [8:0]  m_thrst;
    logic        m_mo;

    typedef struct {
        logic [7:0]  op;
        logic [15:0] d;
        logic [15:0] e_ptch;
        logic [15:0] e_roll;
        logic [15:0] e_yaw;
        logic [8:0]  e_thrst;
        logic        e_mo;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_mo = 1'b1;
    endtask

    task automatic model_apply(input logic [7:0] op, input logic [15:0] d);
        case (op)
            8'h02: m_ptch = d;
            8'h03: m_roll = d;
            8'h04: m_yaw  = d;
            8'h05: m_thrst = d[8:0];
            8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
            8'h08: m_mo = 1'b1;
            default: ;
        endcase
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_ptch"}, d_ptch, m_ptch);
        chk({tag, "_roll"}, d_roll, m_roll);
        chk({tag, "_yaw"}, d_yaw, m_yaw);
        chk({tag, "_thrst"}, thrst, m_thrst);
        chk({tag, "_motors_off"}, motors_off, m_mo);
    endtask

    // Inputs change just after negedge, outputs sampled 1ns later.
    task automatic issue_cmd(input logic [7:0] op, input logic [15:0] d);
        @(negedge clk);
        cmd_rdy = 1'b1; cmd = op; data = d;
        #1;
        chk("ack_clr", clr_cmd_rdy, 1);
        chk("ack_send", send_resp, 1);
        chk("ack_resp", resp, 8'hA5);
        model_apply(op, d);
        @(negedge clk);
        cmd_rdy = 1'b0;
        #1;
        chk("post_clr", clr_cmd_rdy, 0);
        chk("post_send", send_resp, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int strt_at;
        int bad_clr;
        int bad_send;

        vt[0] = '{8'h02, 16'h0050, 16'h0050, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[1] = '{8'h03, 16'hFF80, 16'h0050, 16'hFF80, 16'h0000, 9'h000, 1'b1};
        vt[2] = '{8'h04, 16'h0080, 16'h0050, 16'hFF80, 16'h0080, 9'h000, 1'b1};
        vt[3] = '{8'h05, 16'hFEFF, 16'h0050, 16'hFF80, 16'h0080, 9'h0FF, 1'b1};
        vt[4] = '{8'h1F, 16'h1234, 16'h0050, 16'hFF80, 16'h0080, 9'h0FF, 1'b1};
        vt[5] = '{8'h05, 16'h01AB, 16'h0050, 16'hFF80, 16'h0080, 9'h1AB, 1'b1};
        vt[6] = '{8'h07, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};
        vt[7] = '{8'h08, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 9'h000, 1'b1};

        rst_n = 1'b0; cmd_rdy = 1'b0; cmd = 8'h00; data = 16'h0000; cal_done = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_model("reset");
        chk("reset_inertial_cal", inertial_cal, 0);
        chk("reset_strt_cal", strt_cal, 0);
        chk("reset_send", send_resp, 0);
        chk("reset_clr", clr_cmd_rdy, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_send", send_resp, 0);
        chk("idle_clr", clr_cmd_rdy, 0);

        for (int i = 0; i < 8; i++) begin
            issue_cmd(vt[i].op, vt[i].d);
            chk("vec_ptch", d_ptch, vt[i].e_ptch);
            chk("vec_roll", d_roll, vt[i].e_roll);
            chk("vec_yaw", d_yaw, vt[i].e_yaw);
            chk("vec_thrst", thrst, vt[i].e_thrst);
            chk("vec_motors_off", motors_off, vt[i].e_mo);
        end

        // CALIBRATE with a SET_THRST left pending during RAMP
        @(negedge clk);
        cmd_rdy = 1'b1; cmd = 8'h06; data = 16'h0000;
        #1;
        chk("cal_clr", clr_cmd_rdy, 1);
        chk("cal_send", send_resp, 0);
        @(negedge clk);
        cmd = 8'h05; data = 16'h0080;
        #1;
        chk("cal_motors_off", motors_off, 0);
        chk("cal_inertial", inertial_cal, 1);
        strt_at = -1; bad_clr = 0; bad_send = 0;
        k = 1;
        while (k < 2000 && strt_at < 0) begin
            if (k > 1) begin
                @(negedge clk);
                cal_done = (k == 200 || k == 513);
                #1;
            end
            if (clr_cmd_rdy) bad_clr++;
            if (send_resp) bad_send++;
            if (strt_cal) strt_at = k;
            k++;
        end
        chk("strt_cal_latency", strt_at, 513);
        chk("ramp_clr_count", bad_clr, 0);
        chk("ramp_send_count", bad_send, 0);
        @(negedge clk);
        cal_done = 1'b0;
        #1;
        chk("strt_cal_pulse_width", strt_cal, 0);
        chk("cal_still_inertial", inertial_cal, 1);
        bad_clr = 0; bad_send = 0;
        for (int c = 0; c < 98; c++) begin
            @(negedge clk);
            #1;
            if (clr_cmd_rdy) bad_clr++;
            if (send_resp) bad_send++;
        end
        chk("calwait_clr_count", bad_clr, 0);
        chk("calwait_send_count", bad_send, 0);
        @(negedge clk);
        cal_done = 1'b1;
        #1;
        chk("caldone_send", send_resp, 1);
        chk("caldone_clr", clr_cmd_rdy, 0);
        m_mo = 1'b0;
        @(negedge clk);
        cal_done = 1'b0;
        #1;
        chk("after_cal_inertial", inertial_cal, 0);
        chk("pending_clr", clr_cmd_rdy, 1);
        chk("pending_send", send_resp, 1);
        model_apply(8'h05, 16'h0080);
        @(negedge clk);
        cmd_rdy = 1'b0;
        #1;
        chk("pending_thrst", thrst, 9'h080);
        chk("pending_done_clr", clr_cmd_rdy, 0);
        chk_model("after_cal");

        issue_cmd(8'h02, 16'h1111);
        issue_cmd(8'h03, 16'h2222);
        issue_cmd(8'h04, 16'h3333);
        issue_cmd(8'h05, 16'h01AA);
        issue_cmd(8'h07, 16'h5A5A);
        chk("emer_ptch", d_ptch, 0);
        chk("emer_roll", d_roll, 0);
        chk("emer_yaw", d_yaw, 0);
        chk("emer_thrst", thrst, 0);
        chk("emer_motors_off", motors_off, 0);
        issue_cmd(8'h08, 16'h0000);
        chk("mtrs_off", motors_off, 1);

        // Reset pulse during CAL
        issue_cmd(8'h02, 16'h0777);
        @(negedge clk);
        cmd_rdy = 1'b1; cmd = 8'h06;
        @(negedge clk);
        cmd_rdy = 1'b0;
        k = 0;
        while (k < 2000 && !strt_cal) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("rst_test_reached_cal", strt_cal, 1);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        model_reset();
        chk("rstcal_inertial", inertial_cal, 0);
        chk("rstcal_send", send_resp, 0);
        chk_model("rstcal");
        @(negedge clk);
        cal_done = 1'b1;
        #1;
        chk("idle_caldone_ignored", send_resp, 0);
        @(negedge clk);
        cal_done = 1'b0;

        // Randomized stream, with back-to-back commands when the gap is zero
        for (int i = 0; i < 300; i++) begin
            logic [7:0]  op;
            logic [15:0] d;
            int sel;
            int gap;
            sel = $urandom_range(0, 6);
            case (sel)
                0: op = 8'h02;
                1: op = 8'h03;
                2: op = 8'h04;
                3: op = 8'h05;
                4: op = 8'h07;
                5: op = 8'h08;
                default: op = 8'h10 + 8'($urandom_range(0, 239));
            endcase
            d = 16'($urandom);
            @(negedge clk);
            cmd_rdy = 1'b1; cmd = op; data = d;
            #1;
            chk("rnd_clr", clr_cmd_rdy, 1);
            chk("rnd_send", send_resp, 1);
            chk_model("rnd_pre");
            model_apply(op, d);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                cmd_rdy = 1'b0;
                #1;
                chk("rnd_gap_clr", clr_cmd_rdy, 0);
                chk("rnd_gap_send", send_resp, 0);
                chk_model("rnd_gap");
            end
        end
        @(negedge clk);
        cmd_rdy = 1'b0;
        #1;
        chk_model("rnd_final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_cfg.md
# cmd_cfg

Command interpreter between the UART command receiver and the flight-control datapath. It consumes a decoded host command (8-bit opcode plus 16-bit data) and updates the pitch, roll, yaw and thrust setpoints. It also sequences motor spin-up and inertial calibration, and handles emergency-land and motors-off requests. It returns an ACK byte (0xA5) to the UART transmitter when each command completes.

## Interface
Parameters:
- FAST_SIM, 1, selects the spin-up timer width: 1 gives a 9-bit timer (512 clk), 0 gives a 26-bit timer (about 1.34 s at 50 MHz).

Ports:
- clk  input  1  system clock; single clock domain, all state on rising edge.
- rst_n  input  1  synchronous active-low reset.
- cmd_rdy  input  1  a command/data pair is valid; held high until clr_cmd_rdy.
- cmd  input  8  opcode.
- data  input  16  command payload.
- cal_done  input  1  one-cycle pulse from the inertial interface when calibration finishes.
- clr_cmd_rdy  output  1  one-cycle acknowledge that the command was consumed.
- send_resp  output  1  one-cycle request to transmit resp.
- resp  output  8  constant 8'hA5.
- d_ptch  output  16  signed desired pitch.
- d_roll  output  16  signed desired roll.
- d_yaw  output  16  signed desired yaw.
- thrst  output  9  unsigned desired thrust.
- strt_cal  output  1  one-cycle pulse that starts inertial calibration.
- inertial_cal  output  1  high while spin-up/calibration is in progress.
- motors_off  output  1  forces the ESC outputs to idle.

## Operation
- Opcodes:
  - 0x02 SET_PTCH: d_ptch <= data.
  - 0x03 SET_ROLL: d_roll <= data.
  - 0x04 SET_YAW: d_yaw <= data.
  - 0x05 SET_THRST: thrst <= data[8:0]; data[15:9] is ignored.
  - 0x06 CALIBRATE.
  - 0x07 EMER_LAND: d_ptch, d_roll, d_yaw and thrst all set to 0; motors_off unchanged.
  - 0x08 MTRS_OFF: motors_off <= 1.
  - Any other opcode: no register change, but it is still consumed and ACKed.
- FSM states: IDLE, RAMP, CAL.
- IDLE:
  - If cmd_rdy is high, assert clr_cmd_rdy (Mealy, same cycle).
  - If cmd != 0x06: apply the register update at this edge, assert send_resp in the same cycle, stay in IDLE.
  - If cmd == 0x06: clear motors_off, clear the timer, go to RAMP; send_resp stays low.
- RAMP:
  - inertial_cal = 1 and the timer increments every cycle.
  - When the timer is all-ones, pulse strt_cal for one cycle and go to CAL.
- CAL:
  - inertial_cal = 1.
  - On cal_done, assert send_resp (Mealy, same cycle) and go to IDLE; inertial_cal drops the next cycle.
- CALIBRATE is the only command that clears motors_off.
- Setpoint registers are otherwise held indefinitely.
- cmd_rdy is ignored in RAMP and CAL. clr_cmd_rdy is not asserted there, so a pending command waits and is processed on the first IDLE cycle.

## Timing
- Reset values, all outputs: d_ptch = d_roll = d_yaw = 0, thrst = 0, motors_off = 1, inertial_cal = 0, strt_cal = 0, send_resp = 0, clr_cmd_rdy = 0. The FSM resets to IDLE and the timer to 0.
- Set-type command: clr_cmd_rdy and send_resp are high in the cycle cmd_rdy is first seen in IDLE. The new setpoint is visible the following cycle.
- Back-to-back commands: if cmd_rdy is still high in the cycle after clr_cmd_rdy, it is a new command and is processed. The upstream block must drop cmd_rdy on clr_cmd_rdy.
- CALIBRATE latency, cmd_rdy seen to strt_cal: 1 + 2^N cycles, where N = 9 or 26 depending on FAST_SIM.
  - The timer wraps to 0 on leaving RAMP.
- cal_done arriving in IDLE or RAMP is ignored.
- cal_done arriving in the same cycle as strt_cal (the RAMP to CAL transition) is ignored.
- Reset asserted mid-RAMP or mid-CAL: everything returns to reset values on that edge. No ACK is sent, and motors_off returns to 1.

## Test plan
- Reset, then idle: all setpoints 0, motors_off = 1, no send_resp, clr_cmd_rdy low.
- SET_PTCH 0x0050, SET_ROLL 0xFF80, SET_YAW 0x0080, SET_THRST 0xFEFF:
  - d_ptch = 0x0050, d_roll = 0xFF80, d_yaw = 0x0080, thrst = 0x0FF.
  - Each command gives exactly one clr_cmd_rdy and one send_resp with resp = 0xA5.
- CALIBRATE with FAST_SIM = 1:
  - motors_off falls the next cycle and inertial_cal is high.
  - strt_cal pulses exactly 513 cycles after cmd_rdy is first seen.
  - No ACK is sent until cal_done is pulsed 100 cycles later; then one send_resp, and inertial_cal is low the next cycle.
- SET_THRST 0x0080 issued while in RAMP: not consumed (no clr_cmd_rdy) until the first IDLE cycle after cal_done; then thrst = 0x080 and it is ACKed.
- After nonzero setpoints, EMER_LAND: all four setpoints 0, motors_off still 0, one ACK. Then MTRS_OFF: motors_off = 1, one ACK.
- Unknown opcode 0x1F: consumed and ACKed, no register change. Separately, rst_n low in CAL for one cycle: FSM in IDLE, inertial_cal = 0, motors_off = 1, no send_resp.
